alu_operand_stage: RTL and testbench

- ID/EX boundary stage of the 16-bit pipelined RISC core.
- Decodes each instruction and produces the operand and control form the EX-stage ALU output selector consumes:
  - post-invert operands a_afinv and b_afinv
  - adder carry-in
  - shifter op and shift amount
  - the instruction itself, forwarded.
- Registered, with a valid/ready handshake on both sides and a one-entry skid buffer, so in_ready never depends combinationally on out_ready.

---
 rtl/alu_operand_stage.sv | 203 ++++++++++++++++++++
 tb/tb_alu_operand_stage.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: the ID/EX boundary register of the 16-bit RISC core.
// It decodes each instruction into the operands and controls that the EX
// ALU output selector uses, and registers them behind a one-entry skid
// buffer, so in_ready depends only on registered state.
//
// Ports:
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   flush            squash every held entry and drop this cycle's input
//   in_valid/ready   decode-side handshake; in_ready = !skid_valid
//   instr            instruction word; opcode is instr[15:11]
//   rs_data/rt_data  register operands Rs (instr[10:8]) and Rt (instr[7:5])
//   out_valid/ready  EX-side handshake
//   instr_q          instruction of the entry currently presented
//   a_afinv/b_afinv  ALU operands after any inversion
//   cin              adder carry-in
//   sh_op            shifter op: 00 rol, 01 sll, 10 ror, 11 srl
//   sh_amt           shift amount
module alu_operand_stage #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] instr,
    input  logic [DW-1:0] rs_data,
    input  logic [DW-1:0] rt_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] instr_q,
    output logic [DW-1:0] a_afinv,
    output logic [DW-1:0] b_afinv,
    output logic          cin,
    output logic [1:0]    sh_op,
    output logic [3:0]    sh_amt
);

    typedef struct packed {
        logic [DW-1:0] instr;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          cin;
        logic [1:0]    sh_op;
        logic [3:0]    sh_amt;
    } entry_t;

    localparam entry_t ENTRY_ZERO = '0;

    // ----------------------------------------------------------------
    // Decode
    // ----------------------------------------------------------------
    logic [4:0]    opcode;
    logic [1:0]    func;
    logic [DW-1:0] imm5_s;
    logic [DW-1:0] imm5_z;
    logic [DW-1:0] imm8_z;
    entry_t        dec;

    assign opcode = instr[15:11];
    assign func   = instr[1:0];
    assign imm5_s = {{(DW-5){instr[4]}}, instr[4:0]};
    assign imm5_z = {{(DW-5){1'b0}}, instr[4:0]};
    assign imm8_z = {{(DW-8){1'b0}}, instr[7:0]};

    always_comb begin
        dec.instr  = instr;
        dec.a      = rs_data;
        dec.b      = rt_data;
        dec.cin    = 1'b0;
        dec.sh_op  = 2'b00;
        dec.sh_amt = 4'h0;
        unique casez (opcode)
            5'b01000: begin
                dec.b = imm5_s;
            end
            // SUBI computes imm - Rs as ~Rs + imm + 1
            5'b01001: begin
                dec.a   = ~rs_data;
                dec.b   = imm5_s;
                dec.cin = 1'b1;
            end
            5'b01010: begin
                dec.b = imm5_z;
            end
            5'b01011: begin
                dec.b = ~imm5_z;
            end
            5'b10000,
            5'b10001,
            5'b10011: begin
                dec.b = imm5_s;
            end
            5'b10010: begin
                dec.a = {rs_data[7:0], 8'h00};
                dec.b = imm8_z;
            end
            5'b101??: begin
                dec.b      = imm5_z;
                dec.sh_op  = instr[12:11];
                dec.sh_amt = instr[3:0];
            end
            5'b11010: begin
                dec.sh_op  = func;
                dec.sh_amt = rt_data[3:0];
            end
            5'b11011: begin
                if (func == 2'b01) begin
                    dec.a   = ~rs_data;
                    dec.cin = 1'b1;
                end else if (func == 2'b11) begin
                    dec.b = ~rt_data;
                end
            end
            // compares evaluate Rs - Rt as Rs + ~Rt + 1
            5'b11100,
            5'b11101,
            5'b11110: begin
                dec.b   = ~rt_data;
                dec.cin = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ----------------------------------------------------------------
    // Output register + skid buffer
    // ----------------------------------------------------------------
    entry_t out_q;
    entry_t out_d;
    entry_t skid_q;
    entry_t skid_d;
    logic   out_v_q;
    logic   out_v_d;
    logic   skid_v_q;
    logic   skid_v_d;
    logic   xfer_in;
    logic   xfer_out;

    assign in_ready = !skid_v_q;
    assign xfer_in  = in_valid && in_ready;
    assign xfer_out = out_v_q && out_ready;

    always_comb begin
        out_d    = out_q;
        skid_d   = skid_q;
        out_v_d  = out_v_q;
        skid_v_d = skid_v_q;
        if (flush) begin
            // data is left stale; only the valid bits matter
            out_v_d  = 1'b0;
            skid_v_d = 1'b0;
        end else if (xfer_out) begin
            if (skid_v_q) begin
                // skid drains first to keep FIFO order
                out_d    = skid_q;
                out_v_d  = 1'b1;
                skid_v_d = 1'b0;
                if (xfer_in) begin
                    skid_d   = dec;
                    skid_v_d = 1'b1;
                end
            end else if (xfer_in) begin
                out_d   = dec;
                out_v_d = 1'b1;
            end else begin
                out_v_d = 1'b0;
            end
        end else if (xfer_in) begin
            if (!out_v_q) begin
                out_d   = dec;
                out_v_d = 1'b1;
            end else begin
                skid_d   = dec;
                skid_v_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q    <= ENTRY_ZERO;
            skid_q   <= ENTRY_ZERO;
            out_v_q  <= 1'b0;
            skid_v_q <= 1'b0;
        end else begin
            out_q    <= out_d;
            skid_q   <= skid_d;
            out_v_q  <= out_v_d;
            skid_v_q <= skid_v_d;
        end
    end

    assign out_valid = out_v_q;
    assign instr_q   = out_q.instr;
    assign a_afinv   = out_q.a;
    assign b_afinv   = out_q.b;
    assign cin       = out_q.cin;
    assign sh_op     = out_q.sh_op;
    assign sh_amt    = out_q.sh_amt;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed self-checking bench for alu_operand_stage.
// Each task drives one scenario and compares outputs to hand-computed values.
module tb_alu_operand_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] instr_q;
    logic [15:0] a_afinv;
    logic [15:0] b_afinv;
    logic        cin;
    logic [1:0]  sh_op;
    logic [3:0]  sh_amt;

    int errors = 0;
    int checks = 0;

    wire [54:0] obs = {instr_q, a_afinv, b_afinv, cin, sh_op, sh_amt};

    alu_operand_stage #(.DW(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .instr(instr),
        .rs_data(rs_data),
        .rt_data(rt_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .instr_q(instr_q),
        .a_afinv(a_afinv),
        .b_afinv(b_afinv),
        .cin(cin),
        .sh_op(sh_op),
        .sh_amt(sh_amt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] i, input logic [15:0] rs,
                         input logic [15:0] rt);
        instr    = i;
        rs_data  = rs;
        rt_data  = rt;
        in_valid = 1'b1;
    endtask

    task automatic test_reset;
        tick;
        tick;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== 55'd0) begin
            errors++;
            $display("FAIL reset: ov=%b ir=%b obs=%h want ov=0 ir=1 obs=0",
                     out_valid, in_ready, obs);
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_subi;
        out_ready = 1'b1;
        drive(16'h4A23, 16'h0005, 16'h0000);
        tick;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 ||
            obs !== {16'h4A23, 16'hFFFA, 16'h0003, 1'b1, 2'b00, 4'h0}) begin
            errors++;
            $display("FAIL subi: ov=%b obs=%h", out_valid, obs);
        end
        tick;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL subi_drain: ov=%b want 0", out_valid);
        end
    endtask

    task automatic test_slbi;
        out_ready = 1'b1;
        drive(16'h91AB, 16'h1234, 16'h5555);
        tick;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 ||
            obs !== {16'h91AB, 16'h3400, 16'h00AB, 1'b0, 2'b00, 4'h0}) begin
            errors++;
            $display("FAIL slbi: ov=%b obs=%h", out_valid, obs);
        end
        tick;
    endtask

    task automatic test_rtype;
        out_ready = 1'b1;
        drive(16'hD003, 16'h00AA, 16'h0017);
        tick;
        checks++;
        if (obs !== {16'hD003, 16'h00AA, 16'h0017, 1'b0, 2'b11, 4'h7}) begin
            errors++;
            $display("FAIL rshift: obs=%h", obs);
        end
        drive(16'hD803, 16'h1234, 16'h00F0);
        tick;
        checks++;
        if (obs !== {16'hD803, 16'h1234, 16'hFF0F, 1'b0, 2'b00, 4'h0}) begin
            errors++;
            $display("FAIL andn: obs=%h", obs);
        end
        drive(16'hE800, 16'h0009, 16'h0003);
        tick;
        in_valid = 1'b0;
        checks++;
        if (obs !== {16'hE800, 16'h0009, 16'hFFFC, 1'b1, 2'b00, 4'h0}) begin
            errors++;
            $display("FAIL slt: obs=%h", obs);
        end
        tick;
    endtask

    task automatic test_imm;
        out_ready = 1'b1;
        drive(16'h413F, 16'h0100, 16'h7777);
        tick;
        checks++;
        if (obs !== {16'h413F, 16'h0100, 16'hFFFF, 1'b0, 2'b00, 4'h0}) begin
            errors++;
            $display("FAIL addi_sext: obs=%h", obs);
        end
        drive(16'h5810, 16'h00FF, 16'h7777);
        tick;
        checks++;
        if (obs !== {16'h5810, 16'h00FF, 16'hFFEF, 1'b0, 2'b00, 4'h0}) begin
            errors++;
            $display("FAIL andni: obs=%h", obs);
        end
        drive(16'hA81F, 16'h8001, 16'h7777);
        tick;
        in_valid = 1'b0;
        checks++;
        if (obs !== {16'hA81F, 16'h8001, 16'h001F, 1'b0, 2'b01, 4'hF}) begin
            errors++;
            $display("FAIL shift_imm: obs=%h", obs);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        drive(16'h4101, 16'h0010, 16'h0000);
        tick;
        drive(16'h5005, 16'h0020, 16'h0000);
        checks++;
        if (out_valid !== 1'b1 || instr_q !== 16'h4101 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_0: ov=%b instr=%h ir=%b want 1 4101 1",
                     out_valid, instr_q, in_ready);
        end
        tick;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || instr_q !== 16'h5005 || b_afinv !== 16'h0005) begin
            errors++;
            $display("FAIL b2b_1: ov=%b instr=%h b=%h want 1 5005 0005",
                     out_valid, instr_q, b_afinv);
        end
        tick;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: ov=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        drive(16'h4101, 16'h0010, 16'h0000);
        tick;
        checks++;
        if (out_valid !== 1'b1 || instr_q !== 16'h4101 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_i0: ov=%b instr=%h ir=%b", out_valid, instr_q, in_ready);
        end
        drive(16'h5005, 16'h0020, 16'h0000);
        tick;
        checks++;
        if (in_ready !== 1'b0 || instr_q !== 16'h4101) begin
            errors++;
            $display("FAIL bp_skid: ir=%b instr=%h want 0 4101", in_ready, instr_q);
        end
        drive(16'hD801, 16'h0003, 16'h0001);
        tick;
        tick;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
            obs !== {16'h4101, 16'h0010, 16'h0001, 1'b0, 2'b00, 4'h0}) begin
            errors++;
            $display("FAIL bp_hold: ov=%b ir=%b obs=%h", out_valid, in_ready, obs);
        end
        out_ready = 1'b1;
        tick;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 ||
            obs !== {16'h5005, 16'h0020, 16'h0005, 1'b0, 2'b00, 4'h0}) begin
            errors++;
            $display("FAIL bp_i1: ov=%b ir=%b obs=%h", out_valid, in_ready, obs);
        end
        tick;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 ||
            obs !== {16'hD801, 16'hFFFC, 16'h0001, 1'b1, 2'b00, 4'h0}) begin
            errors++;
            $display("FAIL bp_i2: ov=%b obs=%h", out_valid, obs);
        end
        tick;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_dup: ov=%b instr=%h want ov=0", out_valid, instr_q);
        end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        drive(16'h4102, 16'h0040, 16'h0000);
        tick;
        drive(16'h4103, 16'h0050, 16'h0000);
        tick;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fl_full: ir=%b want 0", in_ready);
        end
        drive(16'h5006, 16'h0060, 16'h0000);
        out_ready = 1'b1;
        flush     = 1'b1;
        tick;
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush: ov=%b ir=%b want 0 1", out_valid, in_ready);
        end
        drive(16'h413F, 16'h0100, 16'h0000);
        tick;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 ||
            obs !== {16'h413F, 16'h0100, 16'hFFFF, 1'b0, 2'b00, 4'h0}) begin
            errors++;
            $display("FAIL fl_after: ov=%b obs=%h", out_valid, obs);
        end
        tick;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL fl_ghost: ov=%b instr=%h want ov=0", out_valid, instr_q);
        end
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0;
        drive(16'h4101, 16'h0010, 16'h0000);
        tick;
        drive(16'h5005, 16'h0020, 16'h0000);
        tick;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== 55'd0) begin
            errors++;
            $display("FAIL async_reset: ov=%b ir=%b obs=%h", out_valid, in_ready, obs);
        end
        #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick;
        tick;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: ov=%b want 0", out_valid);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = '0;
        rs_data   = '0;
        rt_data   = '0;
        test_reset;
        test_subi;
        test_slbi;
        test_rtype;
        test_imm;
        test_back_to_back;
        test_backpressure;
        test_flush;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
